// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO deserializer: FSM encoding, default width
// and the bit-counter width helper.
package sipo_pkg;

    localparam int unsigned SIPO_WIDTH_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_e;

    function automatic int unsigned sipo_cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter for the SIPO deserializer. word_o is the
// assembled word including the bit sampled this cycle.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = SIPO_WIDTH_DEFAULT,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_i,
    input  logic             restart_i,
    input  logic             bit_i,
    output logic             frame_complete_o,
    output logic [WIDTH-1:0] word_o
);

    localparam int unsigned     CW   = sipo_cnt_w(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shift_q, shift_d, base;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        // A restart discards the partial frame so the new bit 0 starts clean.
        base = restart_i ? '0 : shift_q;
        if (MSB_FIRST) begin
            shift_d = {base[WIDTH-2:0], bit_i};
        end else begin
            shift_d = {bit_i, base[WIDTH-1:1]};
        end
        if (!sample_i) begin
            shift_d = shift_q;
        end
    end

    always_comb begin
        frame_complete_o = sample_i && !restart_i && (count_q == LAST);
        count_d          = count_q;
        if (sample_i) begin
            if (restart_i) begin
                count_d = CW'(1);
            end else if (count_q == LAST) begin
                count_d = '0;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    assign word_o = shift_d;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer: frame FSM, one-entry holding register
// with valid/ready handshake, and registered done/overrun pulses.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = SIPO_WIDTH_DEFAULT,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             start,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             done,
    output logic             overrun,
    output logic             busy
);

    sipo_state_e      state_q, state_d;
    logic             restart, frame_complete, drain, load;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d, done_q, done_d, ovr_q, ovr_d;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk              (clk),
        .rst              (rst),
        .sample_i         (serial_valid),
        .restart_i        (restart),
        .bit_i            (serial_in),
        .frame_complete_o (frame_complete),
        .word_o           (word)
    );

    // Kept apart from the next-state logic: frame_complete depends on restart.
    always_comb begin
        restart = 1'b0;
        if (state_q == IDLE) begin
            restart = serial_valid;
        end else begin
            restart = serial_valid & start;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (serial_valid) state_d = SHIFT;
            SHIFT:   if (frame_complete) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        drain   = valid_q & out_ready;
        load    = frame_complete & (~valid_q | drain);
        valid_d = load | (valid_q & ~drain);
        data_d  = load ? word : data_q;
        done_d  = frame_complete;
        ovr_d   = frame_complete & ~load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign parallel_out = data_q;
    assign out_valid    = valid_q;
    assign done         = done_q;
    assign overrun      = ovr_q;
    assign busy         = (state_q == SHIFT);

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: an MSB-first and an LSB-first instance,
// expected words queued as frames are driven and popped at completion.
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       sin, sval, sst, sel_lsb;
    logic       m_sval, l_sval, m_ready, l_ready;
    logic [7:0] m_pout, l_pout;
    logic       m_valid, m_done, m_ovr, m_busy;
    logic       l_valid, l_done, l_ovr, l_busy;

    int         errors = 0;
    int         checks = 0;
    int         m_done_cnt = 0;
    int         l_done_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    assign m_sval = sval & ~sel_lsb;
    assign l_sval = sval & sel_lsb;

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .serial_in(sin), .serial_valid(m_sval), .start(sst),
        .parallel_out(m_pout), .out_valid(m_valid), .out_ready(m_ready),
        .done(m_done), .overrun(m_ovr), .busy(m_busy)
    );

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .serial_in(sin), .serial_valid(l_sval), .start(sst),
        .parallel_out(l_pout), .out_valid(l_valid), .out_ready(l_ready),
        .done(l_done), .overrun(l_ovr), .busy(l_busy)
    );

    always @(posedge clk) begin
        if (m_done === 1'b1) m_done_cnt <= m_done_cnt + 1;
        if (l_done === 1'b1) l_done_cnt <= l_done_cnt + 1;
    end

    task automatic drive_word(input logic [7:0] w, input logic first_start);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sval = 1'b1;
            sst  = (i == 0) && first_start;
            sin  = sel_lsb ? w[i] : w[7-i];
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; sin = 1'b0; sval = 1'b0; sst = 1'b0; sel_lsb = 1'b0;
        m_ready = 1'b0; l_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (m_pout !== 8'h00) begin errors++; $display("FAIL reset_pout: got %h expected 00", m_pout); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
        checks++; if (m_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", m_done); end
        checks++; if (m_ovr !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", m_ovr); end
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", m_busy); end
        checks++; if (l_valid !== 1'b0) begin errors++; $display("FAIL reset_lsb_valid: got %b expected 0", l_valid); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [7:0] e;
        m_ready = 1'b1;
        exp_q.push_back(8'hB3);
        drive_word(8'hB3, 1'b0);
        @(negedge clk);
        sval = 1'b0;
        e = exp_q.pop_front();
        checks++; if (m_pout !== e) begin errors++; $display("FAIL basic_word: got %h expected %h", m_pout, e); end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", m_valid); end
        checks++; if (m_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", m_done); end
        checks++; if (m_ovr !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b expected 0", m_ovr); end
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", m_busy); end
        @(negedge clk);
        checks++; if (m_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", m_done); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %b expected 0", m_valid); end
    endtask

    task automatic test_gaps;
        logic [7:0] w;
        logic [7:0] e;
        int         cnt0;
        w = 8'hB3;
        m_ready = 1'b1;
        cnt0 = m_done_cnt;
        exp_q.push_back(w);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sval = 1'b1; sst = 1'b0; sin = w[7-i];
            if (i < 7) begin
                @(negedge clk);
                sval = 1'b0;
                checks++; if (m_busy !== 1'b1) begin errors++; $display("FAIL gap_busy[%0d]: got %b expected 1", i, m_busy); end
            end
        end
        checks++; if (m_done_cnt != cnt0) begin errors++; $display("FAIL gap_early_done: got %0d pulses expected 0", m_done_cnt - cnt0); end
        @(negedge clk);
        sval = 1'b0;
        e = exp_q.pop_front();
        checks++; if (m_pout !== e) begin errors++; $display("FAIL gap_word: got %h expected %h", m_pout, e); end
        checks++; if (m_done !== 1'b1) begin errors++; $display("FAIL gap_done: got %b expected 1", m_done); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back_overrun;
        logic [15:0] stream;
        logic [7:0]  hold;
        stream  = {8'hB3, 8'hAA};
        hold    = 8'h00;
        m_ready = 1'b0;
        exp_q.push_back(8'hB3);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 8) begin
                hold = exp_q.pop_front();
                checks++; if (m_pout !== hold) begin errors++; $display("FAIL b2b_first_word: got %h expected %h", m_pout, hold); end
                checks++; if (m_done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b expected 1", m_done); end
                checks++; if (m_ovr !== 1'b0) begin errors++; $display("FAIL b2b_first_overrun: got %b expected 0", m_ovr); end
            end
            sval = 1'b1; sst = 1'b0; sin = stream[15-i];
        end
        @(negedge clk);
        sval = 1'b0;
        checks++; if (m_pout !== hold) begin errors++; $display("FAIL overrun_word_held: got %h expected %h", m_pout, hold); end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b expected 1", m_valid); end
        checks++; if (m_done !== 1'b1) begin errors++; $display("FAIL overrun_done: got %b expected 1", m_done); end
        checks++; if (m_ovr !== 1'b1) begin errors++; $display("FAIL overrun_pulse: got %b expected 1", m_ovr); end
        m_ready = 1'b1;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL overrun_drain: got %b expected 0", m_valid); end
        checks++; if (m_ovr !== 1'b0) begin errors++; $display("FAIL overrun_pulse_len: got %b expected 0", m_ovr); end
    endtask

    task automatic test_drain_and_load;
        logic [7:0] e;
        m_ready = 1'b0;
        exp_q.push_back(8'hB3);
        drive_word(8'hB3, 1'b0);
        @(negedge clk);
        sval = 1'b0;
        e = exp_q.pop_front();
        checks++; if (m_pout !== e) begin errors++; $display("FAIL dl_first_word: got %h expected %h", m_pout, e); end
        exp_q.push_back(8'hFF);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sval = 1'b1; sst = 1'b0; sin = 1'b1;
            if (i == 7) m_ready = 1'b1;
        end
        @(negedge clk);
        sval = 1'b0;
        e = exp_q.pop_front();
        checks++; if (m_pout !== e) begin errors++; $display("FAIL dl_word: got %h expected %h", m_pout, e); end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL dl_valid: got %b expected 1", m_valid); end
        checks++; if (m_ovr !== 1'b0) begin errors++; $display("FAIL dl_overrun: got %b expected 0", m_ovr); end
        checks++; if (m_done !== 1'b1) begin errors++; $display("FAIL dl_done: got %b expected 1", m_done); end
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL dl_drained: got %b expected 0", m_valid); end
    endtask

    task automatic test_abort(input logic lsb);
        logic [7:0] e;
        logic [7:0] pout;
        int         cnt0;
        int         cnt1;
        @(negedge clk);
        sval = 1'b0;
        sel_lsb = lsb;
        m_ready = 1'b1; l_ready = 1'b1;
        cnt0 = lsb ? l_done_cnt : m_done_cnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sval = 1'b1; sst = 1'b0; sin = 1'b1;
        end
        exp_q.push_back(8'hE2);
        drive_word(8'hE2, 1'b1);
        @(negedge clk);
        sval = 1'b0;
        e = exp_q.pop_front();
        pout = lsb ? l_pout : m_pout;
        checks++; if (pout !== e) begin errors++; $display("FAIL abort_word(lsb=%b): got %h expected %h", lsb, pout, e); end
        checks++; if ((lsb ? l_valid : m_valid) !== 1'b1) begin errors++; $display("FAIL abort_valid(lsb=%b): got 0 expected 1", lsb); end
        @(negedge clk);
        cnt1 = lsb ? l_done_cnt : m_done_cnt;
        checks++; if (cnt1 - cnt0 != 1) begin errors++; $display("FAIL abort_done_count(lsb=%b): got %0d expected 1", lsb, cnt1 - cnt0); end
        sel_lsb = 1'b0;
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] e;
        sel_lsb = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sval = 1'b1; sst = 1'b0; sin = 1'b1;
        end
        @(negedge clk);
        sval = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (m_pout !== 8'h00) begin errors++; $display("FAIL midrst_pout: got %h expected 00", m_pout); end
        checks++; if (l_pout !== 8'h00) begin errors++; $display("FAIL midrst_lsb_pout: got %h expected 00", l_pout); end
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", m_busy); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", m_valid); end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(8'h55);
        drive_word(8'h55, 1'b0);
        @(negedge clk);
        sval = 1'b0;
        e = exp_q.pop_front();
        checks++; if (m_pout !== e) begin errors++; $display("FAIL midrst_word: got %h expected %h", m_pout, e); end
        checks++; if (m_done !== 1'b1) begin errors++; $display("FAIL midrst_done: got %b expected 1", m_done); end
        checks++; if (m_ovr !== 1'b0) begin errors++; $display("FAIL midrst_overrun: got %b expected 0", m_ovr); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_back_to_back_overrun();
        test_drain_and_load();
        test_abort(1'b0);
        test_abort(1'b1);
        test_reset_mid_frame();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
